// File: rtl/chunked_add_sub_if.sv
// Handshake bundle for the chunked adder/subtractor: operand request on the
// input side, result plus carry/overflow flags on the output side.
interface chunked_add_sub_if #(
   parameter int PA_DATA_WIDTH = 32
);
   logic                     in_valid;
   logic                     in_ready;
   logic [PA_DATA_WIDTH-1:0] in_a;
   logic [PA_DATA_WIDTH-1:0] in_b;
   logic                     carry_in;
   logic                     sub_mode;
   logic                     out_valid;
   logic                     out_ready;
   logic [PA_DATA_WIDTH-1:0] sum_out;
   logic                     carry_out;
   logic                     overflow_out;

   modport master (
      output in_valid, in_a, in_b, carry_in, sub_mode, out_ready,
      input  in_ready, out_valid, sum_out, carry_out, overflow_out
   );

   modport slave (
      input  in_valid, in_a, in_b, carry_in, sub_mode, out_ready,
      output in_ready, out_valid, sum_out, carry_out, overflow_out
   );
endinterface

// File: rtl/chunked_add_sub.sv
// Multi-cycle add/subtract: one PA_CHUNK_WIDTH slice per cycle, LSB first,
// with the carry chained through a register between slices.
module chunked_add_sub #(
   parameter int PA_DATA_WIDTH  = 32,
   parameter int PA_CHUNK_WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   chunked_add_sub_if.slave bus
);
   localparam int NUM_CHUNKS = PA_DATA_WIDTH / PA_CHUNK_WIDTH;
   localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int BASE_W     = (PA_DATA_WIDTH > 1) ? $clog2(PA_DATA_WIDTH) : 1;
   localparam int MSB        = PA_DATA_WIDTH - 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t                   r_state;
   logic [IDX_W-1:0]         r_idx;
   logic [PA_DATA_WIDTH-1:0] r_a;
   logic [PA_DATA_WIDTH-1:0] r_b;
   logic [PA_DATA_WIDTH-1:0] r_acc;
   logic                     r_carry;
   logic                     r_in_ready;
   logic                     r_out_valid;
   logic [PA_DATA_WIDTH-1:0] r_sum;
   logic                     r_carry_out;
   logic                     r_overflow;

   logic [BASE_W-1:0]         w_base;
   logic [PA_CHUNK_WIDTH-1:0] w_a_chunk;
   logic [PA_CHUNK_WIDTH-1:0] w_b_chunk;
   logic [PA_CHUNK_WIDTH-1:0] w_s;
   logic                      w_c;
   logic [PA_DATA_WIDTH-1:0]  w_acc_next;

   assign w_base    = BASE_W'(32'(r_idx) * 32'(PA_CHUNK_WIDTH));
   assign w_a_chunk = r_a[w_base +: PA_CHUNK_WIDTH];
   assign w_b_chunk = r_b[w_base +: PA_CHUNK_WIDTH];

   // Operand B is stored already inverted for subtraction, so one adder serves both modes.
   assign {w_c, w_s} = {1'b0, w_a_chunk} + {1'b0, w_b_chunk}
                     + {{PA_CHUNK_WIDTH{1'b0}}, r_carry};

   always_comb begin
      w_acc_next = r_acc;
      w_acc_next[w_base +: PA_CHUNK_WIDTH] = w_s;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_carry     <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_carry_out <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_a        <= bus.in_a;
                  r_b        <= bus.sub_mode ? ~bus.in_b : bus.in_b;
                  r_carry    <= bus.carry_in ^ bus.sub_mode;
                  r_acc      <= '0;
                  r_idx      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_CALC;
               end
            end
            S_CALC: begin
               r_acc   <= w_acc_next;
               r_carry <= w_c;
               if (r_idx == LAST_IDX) begin
                  r_sum       <= w_acc_next;
                  r_carry_out <= w_c;
                  r_overflow  <= (r_a[MSB] == r_b[MSB]) && (w_acc_next[MSB] != r_a[MSB]);
                  r_out_valid <= 1'b1;
                  r_idx       <= '0;
                  r_state     <= S_DONE;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready     = r_in_ready;
   assign bus.out_valid    = r_out_valid;
   assign bus.sum_out      = r_sum;
   assign bus.carry_out    = r_carry_out;
   assign bus.overflow_out = r_overflow;
endmodule

// File: tb/tb_chunked_add_sub.sv
// Three chunk widths (8, 32, 4) run the same operations side by side; a
// scoreboard checks each against an arithmetic model, latency and hold.
module tb_chunked_add_sub;
   localparam int DW = 32;
   localparam int NL = 3;

   function automatic int cw_of(input int lane);
      case (lane)
         0:       return 8;
         1:       return 32;
         default: return 4;
      endcase
   endfunction

   typedef struct {
      logic [DW-1:0] sum;
      logic          c;
      logic          ov;
      int            acc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] in_a;
   logic [DW-1:0] in_b;
   logic          cin;
   logic          sub;
   logic [NL-1:0] in_ready_l;
   logic [NL-1:0] out_valid_l;
   logic [NL-1:0] out_ready_l;
   logic [NL-1:0] cout_l;
   logic [NL-1:0] ov_l;
   logic [DW-1:0] sum_l [NL];

   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q [NL][$];
   int   stall_l [NL];
   bit   mon_stop = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      chunked_add_sub_if #(.PA_DATA_WIDTH(DW)) bus ();
      assign bus.in_valid  = in_valid;
      assign bus.in_a      = in_a;
      assign bus.in_b      = in_b;
      assign bus.carry_in  = cin;
      assign bus.sub_mode  = sub;
      assign bus.out_ready = out_ready_l[gi];
      assign in_ready_l[gi]  = bus.in_ready;
      assign out_valid_l[gi] = bus.out_valid;
      assign cout_l[gi]      = bus.carry_out;
      assign ov_l[gi]        = bus.overflow_out;
      assign sum_l[gi]       = bus.sum_out;

      chunked_add_sub #(
         .PA_DATA_WIDTH (DW),
         .PA_CHUNK_WIDTH(cw_of(gi))
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .bus(bus)
      );
   end

   task automatic chk(input string name, input int lane,
                      input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s lane%0d(cw=%0d): got 0x%08h, want 0x%08h",
                  name, lane, cw_of(lane), act, req);
      end
   endtask

   // Reference: plain wide arithmetic and signed range test.
   function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic c_in, input logic is_sub);
      exp_t        e;
      longint      sa;
      longint      sb;
      longint      r;
      logic [DW:0] u;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!is_sub) begin
         u     = {1'b0, a} + {1'b0, b} + (DW+1)'(c_in);
         e.sum = u[DW-1:0];
         e.c   = u[DW];
         r     = sa + sb + longint'(c_in);
      end else begin
         e.sum = a - b - DW'(c_in);
         e.c   = ({1'b0, a} >= ({1'b0, b} + (DW+1)'(c_in)));
         r     = sa - sb - longint'(c_in);
      end
      e.ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      e.acc = 0;
      return e;
   endfunction

   task automatic monitor();
      logic [DW-1:0] h_sum [NL];
      logic          h_c [NL];
      logic          h_ov [NL];
      bit            stalled [NL];
      bit            seen [NL];
      exp_t          e;
      for (int l = 0; l < NL; l++) begin
         stalled[l] = 1'b0;
         seen[l]    = 1'b0;
      end
      while (!mon_stop) begin
         @(negedge clk);
         for (int l = 0; l < NL; l++) begin
            if (stalled[l]) begin
               chk("hold_valid", l, DW'(out_valid_l[l]), DW'(1));
               chk("hold_sum", l, sum_l[l], h_sum[l]);
               chk("hold_flags", l, DW'({cout_l[l], ov_l[l]}), DW'({h_c[l], h_ov[l]}));
               chk("hold_in_ready", l, DW'(in_ready_l[l]), DW'(0));
            end
            if (out_valid_l[l]) begin
               if (!seen[l] && exp_q[l].size() > 0) begin
                  chk("latency", l, DW'(cyc - exp_q[l][0].acc), DW'(DW / cw_of(l)));
               end
               seen[l] = 1'b1;
               if (stall_l[l] > 0) begin
                  out_ready_l[l] = 1'b0;
                  stall_l[l]--;
               end else begin
                  out_ready_l[l] = 1'($urandom_range(0, 1));
               end
               stalled[l] = !out_ready_l[l];
               h_sum[l]   = sum_l[l];
               h_c[l]     = cout_l[l];
               h_ov[l]    = ov_l[l];
               if (out_ready_l[l]) begin
                  seen[l] = 1'b0;
                  if (exp_q[l].size() == 0) begin
                     n_vec++;
                     n_err++;
                     $display("FAIL unexpected_result lane%0d: got 0x%08h, want none", l, sum_l[l]);
                  end else begin
                     e = exp_q[l].pop_front();
                     chk("sum", l, sum_l[l], e.sum);
                     chk("carry", l, DW'(cout_l[l]), DW'(e.c));
                     chk("overflow", l, DW'(ov_l[l]), DW'(e.ov));
                  end
               end
            end else begin
               stalled[l]     = 1'b0;
               out_ready_l[l] = 1'($urandom_range(0, 1));
            end
         end
      end
   endtask

   // Waits until every lane is idle; meanwhile garbage is offered only while all are busy.
   task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic c_in, input logic is_sub, input int stall);
      int   t;
      exp_t e;
      t = 0;
      @(negedge clk);
      while (in_ready_l != '1) begin
         if (t++ > 200) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=%b, want %b", in_ready_l, {NL{1'b1}});
            in_valid = 1'b0;
            return;
         end
         if (in_ready_l == '0 && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b1;
            in_a     = $urandom;
            in_b     = $urandom;
            cin      = 1'($urandom_range(0, 1));
            sub      = 1'($urandom_range(0, 1));
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      cin      = c_in;
      sub      = is_sub;
      e        = model(a, b, c_in, is_sub);
      e.acc    = cyc + 1;
      for (int l = 0; l < NL; l++) begin
         exp_q[l].push_back(e);
         stall_l[l] = stall;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = $urandom;
      in_b     = $urandom;
   endtask

   function automatic logic [DW-1:0] rnd_op();
      case ($urandom_range(0, 5))
         0:       return 32'h7FFF_FFFF;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h0000_0000;
         default: return DW'($urandom);
      endcase
   endfunction

   initial begin
      logic [NL-1:0] rose;
      int            t;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_a        = '0;
      in_b        = '0;
      cin         = 1'b0;
      sub         = 1'b0;
      out_ready_l = '0;
      for (int l = 0; l < NL; l++) stall_l[l] = 0;

      repeat (3) @(negedge clk);
      for (int l = 0; l < NL; l++) begin
         chk("rst_out_valid", l, DW'(out_valid_l[l]), DW'(0));
         chk("rst_sum", l, sum_l[l], DW'(0));
         chk("rst_flags", l, DW'({cout_l[l], ov_l[l]}), DW'(0));
      end
      rst = 1'b0;
      @(negedge clk);
      for (int l = 0; l < NL; l++) chk("rst_in_ready", l, DW'(in_ready_l[l]), DW'(1));

      // Abort an operation one edge after it is accepted.
      in_valid = 1'b1;
      in_a     = 32'h1234_5678;
      in_b     = 32'h0FED_CBA9;
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      rose = '0;
      repeat (12) begin
         @(negedge clk);
         rose |= out_valid_l;
      end
      for (int l = 0; l < NL; l++) begin
         chk("abort_no_valid", l, DW'(rose[l]), DW'(0));
         chk("abort_in_ready", l, DW'(in_ready_l[l]), DW'(1));
         chk("abort_sum", l, sum_l[l], DW'(0));
      end

      fork
         monitor();
      join_none

      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
      issue(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
      issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 5);
      issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);
      for (int i = 0; i < 60; i++) begin
         issue(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)));
      end

      t = 0;
      while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      n_vec++;
      if ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending results, want 0",
                  exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
      end
      mon_stop = 1'b1;
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
